// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IMEM_DEPTH     words loaded per session
//   IMEM_ADDR_W    imem address width (2**IMEM_ADDR_W == IMEM_DEPTH)
//   INSTR_W        instruction width, always four bytes
//   loader_state_t loader FSM encoding
package imem_pkg;

  localparam int IMEM_DEPTH     = 8;
  localparam int IMEM_ADDR_W    = 3;
  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = INSTR_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs a stream of bytes into a 32-bit little-endian word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_clear     restart at byte 0 and zero the word
//   i_push      place i_byte in the next byte lane
//   i_byte      data byte
//   o_full      this push completes the word (combinational)
//   o_word      assembled word; byte k sits in bits [8k+7:8k]
module imem_word_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [7:0]         i_byte,
  output logic               o_full,
  output logic [INSTR_W-1:0] o_word
);

  logic [1:0]         r_idx;
  logic [INSTR_W-1:0] r_word;

  // NOTE: state is assigned with <= so every register samples pre-edge values;
  // a blocking = here would let later statements see the updated index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_push) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 2'd1;  // wraps 3 -> 0 for the next word
    end
  end

  assign o_full = i_push && (r_idx == 2'd3);
  assign o_word = r_word;

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: receives bytes over a valid/ready
// handshake, packs four per word and writes DEPTH words to addresses 0..DEPTH-1.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
// byte compared against the mod-256 sum of all data bytes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse; begins a session from IDLE or DONE
//   byte_in/valid     byte stream input, byte_ready is the handshake reply
//   mem_we/addr/wdata imem write port, one write strobe per word
//   busy, done        session status; done held until the next start
//   word_count        words written this session, 0..DEPTH
//   cksum_err         checksum mismatch (0 when the macro is undefined)
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = INSTR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              cksum_err
);

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);

  loader_state_t     r_state;
  logic              r_byte_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_word_count;

  logic               w_accept;
  logic               w_push;
  logic               w_clear;
  logic               w_full;
  logic [INSTR_W-1:0] w_word;

  assign w_accept = byte_valid && r_byte_ready;
  assign w_push   = w_accept && (r_state == ST_COLLECT);
  assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  imem_word_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_byte  (byte_in),
    .o_full  (w_full),
    .o_word  (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_cksum_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum        <= '0;
      r_cksum_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A start while busy never reaches here, so it cannot restart a session.
          if (start) begin
            r_state      <= ST_COLLECT;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_word_count <= '0;
            r_addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum        <= '0;
            r_cksum_err  <= 1'b0;
`endif
          end
        end

        ST_COLLECT: begin
          if (w_accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + byte_in;
`endif
            if (w_full) begin
              r_state      <= ST_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          r_mem_we     <= 1'b0;
          r_word_count <= r_word_count + 1'b1;
          r_addr       <= r_addr + 1'b1;
          if (r_word_count == LAST_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state      <= ST_CHECK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= ST_DONE;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
`endif
          end else begin
            r_state      <= ST_COLLECT;
            r_byte_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            r_cksum_err  <= (byte_in != r_sum);
            r_state      <= ST_DONE;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end
        end
`endif

        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_mem_we     <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready = r_byte_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = WORD_W'(w_word);
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_count = r_word_count;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign cksum_err = r_cksum_err;
`else
  assign cksum_err = 1'b0;
`endif

endmodule
